// File: rtl/bcd_seg_display.sv
// Purpose : binary to 7-segment display driver (decimal via double dabble, or hex), DIGITS digits.
// Latency : HEX_SEG/OVERFLOW update with a one-cycle DONE pulse WIDTH edges after the edge that accepts LOAD.
// Backpr. : LOAD is ignored while BUSY; a LOAD presented in the DONE cycle is accepted.
// Ports   : CLOCK_50 clock; RESET sync active-high; VALUE/MODE (0=dec,1=hex)/LOAD start request;
//           HEX_SEG active-low segments, digit k at [7k+6:7k], bit0=a..bit6=g; BUSY; DONE; OVERFLOW.
// Option  : define BLANK_LEADING_ZERO_EN to blank zero digits above the most significant non-zero digit.
module bcd_seg_display #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic [WIDTH-1:0]      VALUE,
  input  logic                  MODE,
  input  logic                  LOAD,
  output logic [7*DIGITS-1:0]   HEX_SEG,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVERFLOW
);

  // One spare nibble above the displayed digits keeps add-3 carries in range.
  localparam int BCD_W = 4*DIGITS + 4;
  localparam int NIB   = DIGITS + 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic logic [63:0] pow_u(input int base, input int e);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < e; i++) r = r * 64'(base);
    return r;
  endfunction

  localparam logic [63:0] DEC_MAX = pow_u(10, DIGITS) - 64'd1;
  localparam logic [63:0] HEX_LIM = pow_u(16, DIGITS);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t               r_state, w_state_nxt;
  logic                 w_last;
  logic [WIDTH-1:0]     r_val;
  logic                 r_mode;
  logic                 r_ovf_pend;
  logic [BCD_W-1:0]     r_bcd;
  logic [CNT_W-1:0]     r_cnt;
  logic [7*DIGITS-1:0]  r_seg;
  logic                 r_done;
  logic                 r_ovf;
  logic                 w_ovf_in;
  logic [BCD_W-1:0]     w_adj;
  logic [BCD_W-1:0]     w_bcd_nxt;
  logic [7*DIGITS-1:0]  w_seg_nxt;
  logic [3:0]           w_nib;
`ifdef BLANK_LEADING_ZERO_EN
  logic                 w_lead;
`endif

  // Range check is done on the raw captured value, so the shift datapath
  // never has to hold the full magnitude.
  assign w_ovf_in = MODE ? (64'(VALUE) >= HEX_LIM) : (64'(VALUE) > DEC_MAX);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    case (r_state)
      IDLE:    if (LOAD) w_state_nxt = CONVERT;
      CONVERT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Double dabble step: correct digits >= 5 (decimal only), then shift in the next value bit.
  always_comb begin
    w_adj = r_bcd;
    if (!r_mode) begin
      for (int k = 0; k < NIB; k++) begin
        if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
    w_bcd_nxt = {w_adj[BCD_W-2:0], r_val[WIDTH-1]};
  end

  // Glyph selection for the digit register as it will stand after the final shift.
  always_comb begin
    w_seg_nxt = '1;
    w_nib     = 4'd0;
`ifdef BLANK_LEADING_ZERO_EN
    w_lead    = 1'b1;
`endif
    for (int k = DIGITS-1; k >= 0; k--) begin
      w_nib = w_bcd_nxt[4*k +: 4];
      if (r_ovf_pend) begin
        w_seg_nxt[7*k +: 7] = 7'b0111111;
      end else begin
`ifdef BLANK_LEADING_ZERO_EN
        if (w_lead && (w_nib == 4'd0) && (k != 0)) begin
          w_seg_nxt[7*k +: 7] = 7'b1111111;
        end else begin
          w_seg_nxt[7*k +: 7] = seg7(w_nib);
          w_lead              = 1'b0;
        end
`else
        w_seg_nxt[7*k +: 7] = seg7(w_nib);
`endif
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_val      <= '0;
      r_mode     <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_seg      <= '1;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (LOAD) begin
            r_val      <= VALUE;
            r_mode     <= MODE;
            r_ovf_pend <= w_ovf_in;
            r_bcd      <= '0;
            r_cnt      <= CNT_W'(WIDTH);
          end
        end
        CONVERT: begin
          r_val <= {r_val[WIDTH-2:0], 1'b0};
          r_bcd <= w_bcd_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_seg  <= w_seg_nxt;
            r_ovf  <= r_ovf_pend;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign HEX_SEG  = r_seg;
  assign BUSY     = (r_state == CONVERT);
  assign DONE     = r_done;
  assign OVERFLOW = r_ovf;

endmodule

// File: tb/tb_bcd_seg_display.sv
module tb_bcd_seg_display;

  logic        CLOCK_50 = 1'b0;
  logic        RESET    = 1'b1;
  logic [9:0]  VALUE    = '0;
  logic        MODE     = 1'b0;
  logic        LOAD     = 1'b0;
  logic [20:0] HEX_SEG;
  logic        BUSY, DONE, OVERFLOW;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  bcd_seg_display #(.WIDTH(10), .DIGITS(3)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .VALUE(VALUE), .MODE(MODE), .LOAD(LOAD),
    .HEX_SEG(HEX_SEG), .BUSY(BUSY), .DONE(DONE), .OVERFLOW(OVERFLOW)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  localparam logic [6:0] G0 = 7'b1000000, G2 = 7'b0100100, G3 = 7'b0110000,
                         G4 = 7'b0011001, G5 = 7'b0010010, G7 = 7'b1111000,
                         G8 = 7'b0000000, G9 = 7'b0010000, GA = 7'b0001000,
                         GF = 7'b0001110, DASH = 7'b0111111, BLK = 7'b1111111;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;  6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  // Display the value must produce, from plain division by the radix.
  function automatic logic [20:0] model_seg(input int v, input bit hex);
    logic [20:0] s;
    int base, pw, d;
    bit lead;
    base = hex ? 16 : 10;
    s    = '1;
    lead = 1'b1;
    if (v >= base*base*base) return {DASH, DASH, DASH};
    for (int k = 2; k >= 0; k--) begin
      pw = (k == 2) ? base*base : ((k == 1) ? base : 1);
      d  = (v / pw) % base;
`ifdef BLANK_LEADING_ZERO_EN
      if (lead && d == 0 && k != 0) s[7*k +: 7] = BLK;
      else begin s[7*k +: 7] = glyph(d); lead = 1'b0; end
`else
      s[7*k +: 7] = glyph(d);
`endif
    end
    return s;
  endfunction

  // Cycle model: a conversion is a countdown of WIDTH edges after acceptance.
  int          m_cnt = 0;
  bit          m_done = 1'b0, m_ovf = 1'b0, m_pend_ovf = 1'b0;
  logic [20:0] m_seg = '1, m_pend_seg = '1;

  always @(posedge CLOCK_50) begin
    if (RESET) begin
      m_cnt = 0; m_done = 1'b0; m_seg = '1; m_ovf = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin m_done = 1'b1; m_seg = m_pend_seg; m_ovf = m_pend_ovf; end
      end else if (LOAD) begin
        m_cnt      = 10;
        m_pend_seg = model_seg(int'(VALUE), MODE);
        m_pend_ovf = MODE ? (int'(VALUE) >= 4096) : (int'(VALUE) > 999);
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      n_tests++;
      if (HEX_SEG !== m_seg || BUSY !== (m_cnt > 0) || DONE !== m_done || OVERFLOW !== m_ovf) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t seg=%h/%h busy=%b/%b done=%b/%b ovf=%b/%b (got/exp)",
                 $time, HEX_SEG, m_seg, BUSY, (m_cnt > 0), DONE, m_done, OVERFLOW, m_ovf);
      end
    end
  end

  task automatic check_seg(input string name, input logic [20:0] got, input logic [20:0] exp);
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL %s got=%h exp=%h", name, got, exp); end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin n_fail++; $display("FAIL %s got=%0d exp=%0d", name, got, exp); end
  endtask

  // Called just after a negedge; returns after the negedge following the accepting edge.
  task automatic start(input int v, input bit m);
    VALUE = v[9:0]; MODE = m; LOAD = 1'b1;
    @(negedge CLOCK_50);
    LOAD = 1'b0;
  endtask

  // Counts negedges (lat0 already elapsed) until DONE is seen, bounded.
  task automatic wait_done(input int lat0, output int lat, output int nb);
    lat = lat0;
    nb  = (BUSY === 1'b1) ? 1 : 0;
    while (DONE !== 1'b1 && lat < 40) begin
      @(negedge CLOCK_50);
      lat++;
      if (BUSY === 1'b1) nb++;
    end
  endtask

  task automatic run(input int v, input bit m, output int lat, output int nb);
    start(v, m);
    wait_done(1, lat, nb);
  endtask

  int lat, nb, ndone;

  initial begin
    RESET = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    chk_en = 1'b1;
    check_seg("reset_seg", HEX_SEG, 21'h1FFFFF);
    check_int("reset_busy", int'(BUSY), 0);
    check_int("reset_done", int'(DONE), 0);
    check_int("reset_ovf", int'(OVERFLOW), 0);
    RESET = 1'b0;
    @(negedge CLOCK_50);

    run(987, 1'b0, lat, nb);
    check_int("dec987_latency", lat, 11);
    check_int("dec987_busy_cycles", nb, 10);
    check_seg("dec987_seg", HEX_SEG, {G9, G8, G7});
    check_int("dec987_ovf", int'(OVERFLOW), 0);
    @(negedge CLOCK_50);

    run(1000, 1'b0, lat, nb);
    check_int("dec1000_ovf", int'(OVERFLOW), 1);
    check_seg("dec1000_seg", HEX_SEG, {DASH, DASH, DASH});
    @(negedge CLOCK_50);

    run(10'h2AF, 1'b1, lat, nb);
    check_int("hex2AF_latency", lat, 11);
    check_seg("hex2AF_seg", HEX_SEG, {G2, GA, GF});
    check_int("hex2AF_ovf", int'(OVERFLOW), 0);
    @(negedge CLOCK_50);

    run(999, 1'b0, lat, nb);
    check_seg("dec999_seg", HEX_SEG, {G9, G9, G9});
    @(negedge CLOCK_50);

    run(10'h3FF, 1'b1, lat, nb);
    check_seg("hex3FF_seg", HEX_SEG, {G3, GF, GF});
    @(negedge CLOCK_50);

    run(0, 1'b0, lat, nb);
`ifdef BLANK_LEADING_ZERO_EN
    check_seg("dec0_seg", HEX_SEG, {BLK, BLK, G0});
`else
    check_seg("dec0_seg", HEX_SEG, {G0, G0, G0});
`endif
    @(negedge CLOCK_50);

    run(7, 1'b0, lat, nb);
`ifdef BLANK_LEADING_ZERO_EN
    check_seg("dec7_seg", HEX_SEG, {BLK, BLK, G7});
`else
    check_seg("dec7_seg", HEX_SEG, {G0, G0, G7});
`endif
    @(negedge CLOCK_50);

    // LOAD while busy is ignored; LOAD in the DONE cycle starts the next one.
    start(5, 1'b0);
    @(negedge CLOCK_50);
    VALUE = 10'd6; LOAD = 1'b1;
    @(negedge CLOCK_50);
    LOAD = 1'b0;
    @(negedge CLOCK_50);
    wait_done(4, lat, nb);
    check_int("load5_latency", lat, 11);
`ifdef BLANK_LEADING_ZERO_EN
    check_seg("load5_seg", HEX_SEG, {BLK, BLK, G5});
`else
    check_seg("load5_seg", HEX_SEG, {G0, G0, G5});
`endif
    run(42, 1'b0, lat, nb);
    check_int("load_on_done_latency", lat, 11);
`ifdef BLANK_LEADING_ZERO_EN
    check_seg("load42_seg", HEX_SEG, {BLK, G4, G2});
`else
    check_seg("load42_seg", HEX_SEG, {G0, G4, G2});
`endif
    @(negedge CLOCK_50);

    // Reset in the middle of a conversion: no DONE, display blank.
    start(123, 1'b0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET = 1'b1;
    @(negedge CLOCK_50);
    RESET = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLOCK_50);
      if (DONE === 1'b1) ndone++;
    end
    check_int("midreset_no_done", ndone, 0);
    check_seg("midreset_blank", HEX_SEG, 21'h1FFFFF);
    check_int("midreset_busy", int'(BUSY), 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
